// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel programmable clock-enable generator.
// Each channel emits a one-cycle ce_out strobe every N+1 system clocks.
// A new divisor is held in a shadow register and only takes effect at the
// channel's terminal count, so no period is ever truncated or stretched.
// sync_restart zeroes every channel counter in the same cycle, which
// phase-aligns all channels.
// Optional feature macro: CLKDIV_SQUARE_OUT_EN adds a per-channel toggle
// flop on sq_out with 50% duty. When the macro is undefined, sq_out is
// tied low.

module clk_enable_gen #(
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic                    sync_restart,
    output logic [NUM_CH-1:0]       ce_out,
    output logic [NUM_CH-1:0]       sq_out,
    output logic [NUM_CH-1:0]       pending
);

    localparam logic [DIV_W-1:0] RESET_DIV_C = DIV_W'(RESET_DIV);
    localparam logic [DIV_W-1:0] CNT_ZERO_C  = DIV_W'(0);
    localparam logic [DIV_W-1:0] CNT_ONE_C   = DIV_W'(1);

    genvar ch;
    generate
        for (ch = 0; ch < NUM_CH; ch = ch + 1) begin : g_ch
            logic [DIV_W-1:0] cnt_r;
            logic [DIV_W-1:0] act_r;
            logic [DIV_W-1:0] shd_r;
            logic             pend_r;
            logic             ce_r;
            logic [DIV_W-1:0] cnt_nxt_s;
            logic [DIV_W-1:0] act_nxt_s;
            logic [DIV_W-1:0] shd_nxt_s;
            logic             pend_nxt_s;
            logic             ce_nxt_s;
            logic [DIV_W-1:0] div_slice_s;
            logic             wrap_s;

            assign div_slice_s = div_val[ch*DIV_W +: DIV_W];
            // Terminal count; cnt never exceeds act, so equality is sufficient.
            assign wrap_s      = (cnt_r == act_r);

            // Next-state logic: restart, terminal-count wrap with divisor swap, shadow load.
            always_comb begin
                cnt_nxt_s  = cnt_r;
                act_nxt_s  = act_r;
                shd_nxt_s  = shd_r;
                pend_nxt_s = pend_r;
                ce_nxt_s   = 1'b0;
                if (sync_restart) begin
                    cnt_nxt_s  = CNT_ZERO_C;
                    ce_nxt_s   = 1'b0;
                    pend_nxt_s = 1'b0;
                    if (div_load[ch]) begin
                        // A fresh value on the restart edge bypasses the shadow.
                        act_nxt_s = div_slice_s;
                        shd_nxt_s = div_slice_s;
                    end else if (pend_r) begin
                        act_nxt_s = shd_r;
                    end else begin
                        act_nxt_s = act_r;
                    end
                end else begin
                    if (wrap_s) begin
                        cnt_nxt_s = CNT_ZERO_C;
                        ce_nxt_s  = 1'b1;
                        if (pend_r) begin
                            // The old shadow value is applied; a load in this same
                            // cycle stays pending until the following wrap.
                            act_nxt_s  = shd_r;
                            pend_nxt_s = 1'b0;
                        end else begin
                            act_nxt_s = act_r;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE_C;
                        ce_nxt_s  = 1'b0;
                    end
                    if (div_load[ch]) begin
                        shd_nxt_s  = div_slice_s;
                        pend_nxt_s = 1'b1;
                    end else begin
                        shd_nxt_s = shd_r;
                    end
                end
            end

            // Channel state registers with asynchronous reset to the boot divisor.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_r  <= CNT_ZERO_C;
                    act_r  <= RESET_DIV_C;
                    shd_r  <= RESET_DIV_C;
                    pend_r <= 1'b0;
                    ce_r   <= 1'b0;
                end else begin
                    cnt_r  <= cnt_nxt_s;
                    act_r  <= act_nxt_s;
                    shd_r  <= shd_nxt_s;
                    pend_r <= pend_nxt_s;
                    ce_r   <= ce_nxt_s;
                end
            end

            assign ce_out[ch]  = ce_r;
            assign pending[ch] = pend_r;

`ifdef CLKDIV_SQUARE_OUT_EN
            logic sq_r;
            logic sq_nxt_s;

            // Square-wave next state: cleared on restart, toggled at every wrap.
            always_comb begin
                sq_nxt_s = sq_r;
                if (sync_restart) begin
                    sq_nxt_s = 1'b0;
                end else if (wrap_s) begin
                    sq_nxt_s = ~sq_r;
                end else begin
                    sq_nxt_s = sq_r;
                end
            end

            // Square-wave toggle flop, edge-aligned with ce_out.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sq_r <= 1'b0;
                end else begin
                    sq_r <= sq_nxt_s;
                end
            end

            assign sq_out[ch] = sq_r;
`else
            assign sq_out[ch] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen (NUM_CH=2, DIV_W=8, RESET_DIV=1).
// The reference model tracks each channel as an integer period (N+1) and a
// phase within that period. It applies divisor changes at period boundaries,
// as the datasheet rules describe.

module tb_clk_enable_gen;

    localparam int NUM_CH    = 2;
    localparam int DIV_W     = 8;
    localparam int RESET_DIV = 1;
`ifdef CLKDIV_SQUARE_OUT_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif

    logic                    clk;
    logic                    rst;
    logic [NUM_CH*DIV_W-1:0] div_val;
    logic [NUM_CH-1:0]       div_load;
    logic                    sync_restart;
    logic [NUM_CH-1:0]       ce_out;
    logic [NUM_CH-1:0]       sq_out;
    logic [NUM_CH-1:0]       pending;

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per channel.
    int per_m  [NUM_CH];
    int ph_m   [NUM_CH];
    int shd_m  [NUM_CH];
    bit pend_m [NUM_CH];
    bit ce_m   [NUM_CH];
    bit sq_m   [NUM_CH];

    clk_enable_gen #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .RESET_DIV(RESET_DIV)
    ) dut (
        .clk(clk), .rst(rst), .div_val(div_val), .div_load(div_load),
        .sync_restart(sync_restart), .ce_out(ce_out), .sq_out(sq_out),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            per_m[c]  = RESET_DIV + 1;
            ph_m[c]   = 0;
            shd_m[c]  = RESET_DIV;
            pend_m[c] = 1'b0;
            ce_m[c]   = 1'b0;
            sq_m[c]   = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_edge();
        int v;
        for (int c = 0; c < NUM_CH; c++) begin
            v = int'(div_val[c*DIV_W +: DIV_W]);
            if (rst) begin
                per_m[c] = RESET_DIV + 1; ph_m[c] = 0; shd_m[c] = RESET_DIV;
                pend_m[c] = 1'b0; ce_m[c] = 1'b0; sq_m[c] = 1'b0;
            end else if (sync_restart) begin
                ph_m[c] = 0; ce_m[c] = 1'b0; sq_m[c] = 1'b0;
                if (div_load[c]) begin
                    per_m[c] = v + 1; shd_m[c] = v;
                end else if (pend_m[c]) begin
                    per_m[c] = shd_m[c] + 1;
                end
                pend_m[c] = 1'b0;
            end else begin
                if (ph_m[c] == per_m[c] - 1) begin
                    ce_m[c] = 1'b1; ph_m[c] = 0; sq_m[c] = !sq_m[c];
                    if (pend_m[c]) begin
                        per_m[c] = shd_m[c] + 1; pend_m[c] = 1'b0;
                    end
                end else begin
                    ce_m[c] = 1'b0; ph_m[c] = ph_m[c] + 1;
                end
                if (div_load[c]) begin
                    shd_m[c] = v; pend_m[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_outputs(output logic [NUM_CH-1:0] e_ce,
                                 output logic [NUM_CH-1:0] e_sq,
                                 output logic [NUM_CH-1:0] e_pend);
        for (int c = 0; c < NUM_CH; c++) begin
            e_ce[c]   = ce_m[c];
            e_sq[c]   = SQ_EN ? sq_m[c] : 1'b0;
            e_pend[c] = pend_m[c];
        end
    endtask

    // One clock: wait for the edge, update the model, then settle 1 time unit.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Step and compare all outputs against the model.
    task automatic step_cmp(input string tag);
        logic [NUM_CH-1:0] e_ce, e_sq, e_pend;
        step();
        model_outputs(e_ce, e_sq, e_pend);
        checks++;
        if ({ce_out, sq_out, pending} !== {e_ce, e_sq, e_pend}) begin
            errors++;
            $display("FAIL %s t=%0t: ce/sq/pend got %b/%b/%b expected %b/%b/%b",
                     tag, $time, ce_out, sq_out, pending, e_ce, e_sq, e_pend);
        end
    endtask

    task automatic set_div(input int c, input int v);
        div_val[c*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    task automatic test_reset();
        int strobes;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({ce_out, sq_out, pending} !== '0) begin
                errors++;
                $display("FAIL reset_hold: outputs got %b expected 0", {ce_out, sq_out, pending});
            end
        end
        rst = 1'b0;
        strobes = 0;
        for (int k = 1; k <= 8; k++) begin
            step_cmp("reset_run");
            checks++;
            if (ce_out !== ((k % 2 == 0) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL reset_period edge %0d: ce_out got %b expected %b",
                         k, ce_out, (k % 2 == 0) ? 2'b11 : 2'b00);
            end
            if (ce_out[0]) strobes++;
        end
        checks++;
        if (strobes !== 4) begin
            errors++;
            $display("FAIL reset_strobes: got %0d expected 4", strobes);
        end
    endtask

    task automatic test_load_mid();
        int guard;
        int last_ce, gap;
        guard = 0;
        while (ph_m[0] != 1 && guard < 50) begin step_cmp("load_mid_wait"); guard++; end
        checks++;
        if (guard >= 50) begin errors++; $display("FAIL load_mid_wait: phase 1 not reached got %0d expected 1", ph_m[0]); end
        set_div(0, 4); div_load = 2'b01;
        step_cmp("load_mid_load");
        div_load = 2'b00;
        checks++;
        if (pending[0] !== 1'b1) begin errors++; $display("FAIL load_mid_pending: got %b expected 1", pending[0]); end
        last_ce = -1; gap = 0;
        for (int k = 0; k < 20; k++) begin
            step_cmp("load_mid_run");
            if (ce_out[0]) begin
                if (last_ce >= 0) gap = k - last_ce;
                last_ce = k;
            end
        end
        checks++;
        if (gap !== 5 || pending[0] !== 1'b0) begin
            errors++;
            $display("FAIL load_mid_period: gap got %0d pend %b expected 5 pend 0", gap, pending[0]);
        end
    endtask

    task automatic test_double_load();
        int last_ce, gap;
        set_div(1, 5); div_load = 2'b10;
        step_cmp("dbl_pre");
        div_load = 2'b00;
        for (int k = 0; k < 14; k++) step_cmp("dbl_settle");
        set_div(1, 0); div_load = 2'b10;
        step_cmp("dbl_load0");
        set_div(1, 7);
        step_cmp("dbl_load7");
        div_load = 2'b00;
        last_ce = -1; gap = 0;
        for (int k = 0; k < 30; k++) begin
            step_cmp("dbl_run");
            if (ce_out[1]) begin
                if (last_ce >= 0) gap = k - last_ce;
                last_ce = k;
            end
        end
        checks++;
        if (gap !== 8) begin errors++; $display("FAIL dbl_period: gap got %0d expected 8", gap); end
    endtask

    task automatic test_load_at_wrap();
        int guard;
        guard = 0;
        while (ph_m[0] != per_m[0] - 1 && guard < 50) begin step_cmp("wrap_wait"); guard++; end
        checks++;
        if (guard >= 50) begin errors++; $display("FAIL wrap_wait: wrap not reached got %0d expected %0d", ph_m[0], per_m[0] - 1); end
        set_div(0, 2); div_load = 2'b01;
        step_cmp("wrap_load");
        div_load = 2'b00;
        checks++;
        if (pending[0] !== 1'b1 || ce_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_same_cycle: ce %b pend %b expected ce 1 pend 1", ce_out[0], pending[0]);
        end
        for (int k = 0; k < 20; k++) step_cmp("wrap_run");
    endtask

    task automatic test_restart();
        int first0, first1;
        set_div(0, 3); set_div(1, 5); div_load = 2'b11;
        step_cmp("rs_load");
        div_load = 2'b00;
        for (int k = 0; k < 20; k++) step_cmp("rs_free");
        sync_restart = 1'b1;
        step_cmp("rs_edge");
        sync_restart = 1'b0;
        first0 = 0; first1 = 0;
        for (int k = 1; k <= 8; k++) begin
            step_cmp("rs_run");
            if (ce_out[0] && first0 == 0) first0 = k;
            if (ce_out[1] && first1 == 0) first1 = k;
        end
        checks++;
        if (first0 !== 4 || first1 !== 6) begin
            errors++;
            $display("FAIL rs_align: first ce got %0d/%0d expected 4/6", first0, first1);
        end
        set_div(1, 1); div_load = 2'b10; sync_restart = 1'b1;
        step_cmp("rs_load_edge");
        div_load = 2'b00; sync_restart = 1'b0;
        first0 = 0; first1 = 0;
        for (int k = 1; k <= 6; k++) begin
            step_cmp("rs_load_run");
            if (ce_out[0] && first0 == 0) first0 = k;
            if (ce_out[1] && first1 == 0) first1 = k;
        end
        checks++;
        if (first0 !== 4 || first1 !== 2) begin
            errors++;
            $display("FAIL rs_direct_load: first ce got %0d/%0d expected 4/2", first0, first1);
        end
    endtask

    task automatic test_square_and_midreset();
        logic exp_sq;
        set_div(0, 3); div_load = 2'b01; sync_restart = 1'b1;
        step_cmp("sq_edge");
        div_load = 2'b00; sync_restart = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step_cmp("sq_run");
            exp_sq = SQ_EN ? (((k / 4) % 2) == 1) : 1'b0;
            checks++;
            if (sq_out[0] !== exp_sq) begin
                errors++;
                $display("FAIL sq_shape step %0d: got %b expected %b", k, sq_out[0], exp_sq);
            end
        end
        // Sit right after a wrap (ce high, sq high when enabled), then reset asynchronously.
        while (!(ce_m[0] && (sq_m[0] || !SQ_EN))) step_cmp("midrst_wait");
        set_div(1, 6); div_load = 2'b10;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({ce_out, sq_out, pending} !== '0) begin
            errors++;
            $display("FAIL midrst_async: outputs got %b expected 0", {ce_out, sq_out, pending});
        end
        step_cmp("midrst_hold");
        rst = 1'b0; div_load = 2'b00;
        for (int k = 0; k < 10; k++) step_cmp("midrst_after");
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                set_div(c, $urandom_range(0, 6));
                div_load[c] = ($urandom_range(0, 7) == 0);
            end
            sync_restart = ($urandom_range(0, 39) == 0);
            step_cmp("random");
        end
        div_load = 2'b00; sync_restart = 1'b0;
    endtask

    initial begin
        rst = 1'b1; div_val = '0; div_load = '0; sync_restart = 1'b0;
        model_reset();
        test_reset();
        test_load_mid();
        test_double_load();
        test_load_at_wrap();
        test_restart();
        test_square_and_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Multi-channel, run-time programmable clock-enable generator; the parametrised successor to the fixed power-of-two clock divider in the BLDC PID datapath. Each channel produces single-cycle enable strobes at a programmable period from the one system clock, so the PID, ESC counter and sampling logic stay in one clock domain. Divisors change glitch-free at terminal count, and a global restart phase-aligns all channels.

## Interface
- NUM_CH, 2, number of independent channels (1..8)
- DIV_W, 8, divisor width per channel
- RESET_DIV, 1, divisor loaded into every channel at reset (must fit in DIV_W)

- clk  in  1  system clock (25 MHz nominal)
- rst  in  1  reset, asynchronous, active-high
- div_val  in  NUM_CH*DIV_W  requested divisor N per channel; channel i uses bits [i*DIV_W +: DIV_W]
- div_load  in  NUM_CH  per-channel strobe; latch div_val slice into that channel's shadow register
- sync_restart  in  1  strobe; restart all channel counters together
- ce_out  out  NUM_CH  per-channel enable strobe, one cycle high, period N+1 cycles
- sq_out  out  NUM_CH  per-channel square wave, period 2(N+1), 50% duty (see Configuration)
- pending  out  NUM_CH  shadow divisor latched but not yet applied

## Operation
- Per channel: counter cnt[DIV_W-1:0], active divisor act[DIV_W-1:0], shadow shd, flag pend.
- Reset (async): cnt=0, act=shd=RESET_DIV, pend=0, ce_out=0, sq_out=0, pending=0.
- Each cycle: if cnt==act then cnt<=0 and ce_out<=1, else cnt<=cnt+1 and ce_out<=0. Unsigned compare; no overflow since cnt never exceeds act.
- N=0: ce_out high every cycle (period 1).
- div_load[i]: shd<=div_val slice, pend<=1. Repeated loads before application: last value wins.
- Application: on the wrap cycle (cnt==act) with pend=1, act<=shd, pend<=0; the new period starts from the next cnt=0. No truncated or stretched period ever produced.
- div_load on the same cycle as a wrap: the wrap applies the old shd (if pending); new value stays pending until next wrap.
- sync_restart: all cnt<=0, ce_out<=0, any pending shd applied immediately, pend<=0; sq_out<=0.
- sync_restart together with div_load[i]: the div_val slice is applied directly to act (overrides shd), pend<=0.
- Reset mid-operation: all state returns to reset values immediately; pending loads are discarded.
- pending output = pend flags, registered.

## Timing
- ce_out registered; asserted the cycle after the edge where cnt==act is sampled. With act=3 and rst released before edge 1: ce_out high after edges 4, 8, 12, ...
- div_load to pending visible: 1 cycle.
- Latency div_load to new period: up to act+1 cycles (waits for current period to finish).
- sync_restart: first ce_out exactly act+1 cycles after the restart edge, on all channels simultaneously when divisors are equal.
- sq_out toggles on the same edge ce_out is set.

## Configuration
- CLKDIV_SQUARE_OUT_EN defined: per-channel toggle flop drives sq_out, toggling at each wrap; reset/sync_restart clear it to 0.
- Not defined: sq_out tied to 0, no toggle flops synthesised; ce_out behaviour identical.

## Test plan
- Reset with RESET_DIV=1, NUM_CH=2 -> both ce_out high every 2nd cycle, all outputs 0 during rst.
- Load N=4 on ch0 mid-period at cnt=1 -> pending[0]=1 next cycle; old period completes, then ce_out every 5 cycles, pending clears at wrap.
- Load N=0 then N=7 on ch1 within one period -> only N=7 applied (period 8).
- Load N=2 on ch0 at the wrap cycle -> current wrap uses old value; N=2 applied at following wrap.
- ch0 N=3, ch1 N=5 free-running, assert sync_restart -> both counters zeroed, ch0 ce after 4 cycles, ch1 after 6; with div_load[1]=1 and div_val ch1=1 on same edge, ch1 ce after 2 cycles.
- With CLKDIV_SQUARE_OUT_EN, N=3 -> sq_out period 8, 4 high/4 low; assert rst mid-high -> sq_out drops to 0 immediately.
